// File: rtl/fir_tap_mac.sv
// fir_tap_mac: sequential 8-tap FIR multiply-accumulate engine.
// It snapshots the tap window on start and then uses one shared multiplier
// for 8 cycles (one tap per cycle). The result is registered on y_o, and
// y_valid_o pulses for one cycle when y_o updates. The coefficient bank
// holds 8 signed entries and can only be written while the engine is idle.
// Optional feature macro: FIR_MAC_SAT_EN. When it is defined, the output
// saturates. When it is undefined, the output wraps in two's complement.
module fir_tap_mac #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] a0_i,
    input  logic [DATA_W-1:0] a1_i,
    input  logic [DATA_W-1:0] a2_i,
    input  logic [DATA_W-1:0] a3_i,
    input  logic [DATA_W-1:0] a4_i,
    input  logic [DATA_W-1:0] a5_i,
    input  logic [DATA_W-1:0] a6_i,
    input  logic [DATA_W-1:0] a7_i,
    input  logic              coef_we_i,
    input  logic [2:0]        coef_addr_i,
    input  logic [COEF_W-1:0] coef_data_i,
    output logic              busy_o,
    output logic [OUT_W-1:0]  y_o,
    output logic              y_valid_o
);

    // The product is a zero-extended tap times a signed coefficient.
    // The accumulator has 3 guard bits, which is enough for a sum of 8 products.
    localparam int PROD_W = DATA_W + 1 + COEF_W;
    localparam int ACC_W  = PROD_W + 3;

`ifdef FIR_MAC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    // Output clamp limits, sign-extended to the accumulator width.
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        signed'({{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        signed'({{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Reduce the shifted accumulator to the output width.
    // In saturating builds it clamps; otherwise it keeps the low OUT_W bits.
    function automatic logic [OUT_W-1:0] sat_or_wrap(input logic signed [ACC_W-1:0] v);
        logic [OUT_W-1:0] r;
        if (SAT_EN && (v > SAT_MAX)) begin
            r = SAT_MAX[OUT_W-1:0];
        end else if (SAT_EN && (v < SAT_MIN)) begin
            r = SAT_MIN[OUT_W-1:0];
        end else begin
            r = v[OUT_W-1:0];
        end
        return r;
    endfunction

    state_t                    state_q, state_d;
    logic [DATA_W-1:0]         tap_q [8];
    logic [DATA_W-1:0]         tap_d [8];
    logic [COEF_W-1:0]         coef_q [8];
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [2:0]                idx_q, idx_d;
    logic [OUT_W-1:0]          y_q, y_d;
    logic                      y_valid_q, y_valid_d;
    logic                      busy_q, busy_d;

    logic signed [DATA_W:0]    tap_ext_s;
    logic signed [COEF_W-1:0]  coef_sel_s;
    logic signed [PROD_W-1:0]  prod_s;
    logic signed [ACC_W-1:0]   prod_ext_s;
    logic signed [ACC_W-1:0]   acc_sh_s;

    // Shared multiplier: the tap and coefficient selected by idx, with the product sign-extended.
    always_comb begin
        tap_ext_s  = signed'({1'b0, tap_q[idx_q]});
        coef_sel_s = signed'(coef_q[idx_q]);
        prod_s     = tap_ext_s * coef_sel_s;
        prod_ext_s = {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
        acc_sh_s   = acc_q >>> SHIFT;
    end

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> MAC on start, 8 MAC cycles, one OUT cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_MAC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MAC: begin
                if (idx_q == 3'd7) begin
                    state_d = ST_OUT;
                end else begin
                    state_d = ST_MAC;
                end
            end
            ST_OUT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and output next values for each state.
    always_comb begin
        tap_d     = tap_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        y_d       = y_q;
        y_valid_d = 1'b0;
        busy_d    = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    tap_d[0] = a0_i;
                    tap_d[1] = a1_i;
                    tap_d[2] = a2_i;
                    tap_d[3] = a3_i;
                    tap_d[4] = a4_i;
                    tap_d[5] = a5_i;
                    tap_d[6] = a6_i;
                    tap_d[7] = a7_i;
                    acc_d    = '0;
                    idx_d    = 3'd0;
                    busy_d   = 1'b1;
                end else begin
                    busy_d   = 1'b0;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + prod_ext_s;
                idx_d = idx_q + 3'd1;
            end
            ST_OUT: begin
                y_d       = sat_or_wrap(acc_sh_s);
                y_valid_d = 1'b1;
                busy_d    = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers. An asynchronous reset aborts any computation in flight.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int k = 0; k < 8; k++) begin
                tap_q[k] <= '0;
            end
            acc_q     <= '0;
            idx_q     <= 3'd0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            tap_q     <= tap_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            busy_q    <= busy_d;
        end
    end

    // Coefficient bank. Writes are accepted only in IDLE, so the bank stays stable during MAC.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int k = 0; k < 8; k++) begin
                coef_q[k] <= '0;
            end
        end else if (coef_we_i && (state_q == ST_IDLE)) begin
            coef_q[coef_addr_i] <= coef_data_i;
        end else begin
            coef_q <= coef_q;
        end
    end

    assign busy_o    = busy_q;
    assign y_o       = y_q;
    assign y_valid_o = y_valid_q;

endmodule

// File: tb/tb_fir_tap_mac.sv
// Directed testbench for fir_tap_mac. A table of coefficient/tap/result
// vectors is followed by hand-written sequences for reset, snapshot, abort
// and back-to-back behaviour. Expected values depend on FIR_MAC_SAT_EN.
module tb_fir_tap_mac;

    logic        clk;
    logic        reset;
    logic        start;
    logic [63:0] taps_v;
    logic        coef_we;
    logic [2:0]  coef_addr;
    logic [7:0]  coef_data;
    logic        busy;
    logic [15:0] y;
    logic        y_valid;

    int pass_cnt  = 0;
    int total_cnt = 0;

    fir_tap_mac dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .a0_i        (taps_v[7:0]),
        .a1_i        (taps_v[15:8]),
        .a2_i        (taps_v[23:16]),
        .a3_i        (taps_v[31:24]),
        .a4_i        (taps_v[39:32]),
        .a5_i        (taps_v[47:40]),
        .a6_i        (taps_v[55:48]),
        .a7_i        (taps_v[63:56]),
        .coef_we_i   (coef_we),
        .coef_addr_i (coef_addr),
        .coef_data_i (coef_data),
        .busy_o      (busy),
        .y_o         (y),
        .y_valid_o   (y_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] coefs;   // byte k = coef k
        logic [63:0] taps;    // byte k = Ak
        logic [15:0] y_exp;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_coefs(input logic [63:0] c);
        for (int k = 0; k < 8; k++) begin
            coef_we   = 1'b1;
            coef_addr = 3'(k);
            coef_data = c[8*k +: 8];
            tick();
        end
        coef_we = 1'b0;
    endtask

    // Pulse start and wait (bounded) for y_valid. Returns latency in edges, y, and busy-high samples.
    task automatic run_vec(input logic [63:0] t, output int lat, output logic [15:0] yv, output int busy_cnt);
        taps_v   = t;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        lat      = -1;
        yv       = 16'h0;
        busy_cnt = busy ? 1 : 0;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            tick();
            if (y_valid) begin
                lat = c;
                yv  = y;
            end else if (busy) begin
                busy_cnt++;
            end
        end
    endtask

    int          lat;
    logic [15:0] yv;
    int          bcnt;
    int          pulses;
    int          early;

    initial begin
        reset     = 1'b1;
        start     = 1'b1;
        taps_v    = 64'h0807060504030201;
        coef_we   = 1'b0;
        coef_addr = 3'd0;
        coef_data = 8'd0;

        vecs[0] = '{"basic",     64'h0101010101010101, 64'h0807060504030201, 16'd36};
`ifdef FIR_MAC_SAT_EN
        vecs[1] = '{"ovf_pos",   64'h7F7F7F7F7F7F7F7F, 64'hFFFFFFFFFFFFFFFF, 16'h7FFF};
        vecs[2] = '{"ovf_neg",   64'h8080808080808080, 64'hFFFFFFFFFFFFFFFF, 16'h8000};
`else
        vecs[1] = '{"ovf_pos",   64'h7F7F7F7F7F7F7F7F, 64'hFFFFFFFFFFFFFFFF, 16'hF408};
        vecs[2] = '{"ovf_neg",   64'h8080808080808080, 64'hFFFFFFFFFFFFFFFF, 16'h0400};
`endif
        vecs[3] = '{"neg_coef",  64'hFFFFFFFFFFFFFFFF, 64'h0A0A0A0A0A0A0A0A, 16'hFFB0};
        vecs[4] = '{"ramp_coef", 64'h0706050403020100, 64'h0202020202020202, 16'd56};
        vecs[5] = '{"mixed",     64'h0A0001F90500FE03, 64'h014DFF0904C83264, 16'd422};

        // Reset held with the clock running and start high: no activity.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_y", 32'(y), 32'd0);
            check("rst_valid", 32'(y_valid), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
        end
        start = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        check("post_rst_busy", 32'(busy), 32'd0);

        // Table-driven vectors.
        for (int v = 0; v < 6; v++) begin
            load_coefs(vecs[v].coefs);
            run_vec(vecs[v].taps, lat, yv, bcnt);
            check({vecs[v].name, "_lat"}, 32'(lat), 32'd9);
            check({vecs[v].name, "_y"}, 32'(yv), 32'(vecs[v].y_exp));
            check({vecs[v].name, "_busy_cycles"}, 32'(bcnt), 32'd9);
            check({vecs[v].name, "_busy_low"}, 32'(busy), 32'd0);
            tick();
            check({vecs[v].name, "_valid_1cyc"}, 32'(y_valid), 32'd0);
        end

        // Snapshot: taps change after start, a second start and a coef write come during MAC.
        load_coefs(64'h0101010101010101);
        taps_v = 64'h0807060504030201;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        taps_v = 64'h0;
        pulses = 0;
        early  = 0;
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (c == 3) begin
                start     = 1'b1;
                coef_we   = 1'b1;
                coef_addr = 3'd7;
                coef_data = 8'd100;
            end else if (c == 4) begin
                start   = 1'b0;
                coef_we = 1'b0;
            end
            if (y_valid) pulses++;
            if (c < 9 && !busy) early++;
            if (c == 9) begin
                check("snap_valid", 32'(y_valid), 32'd1);
                check("snap_y", 32'(y), 32'd36);
            end
        end
        check("snap_pulses", 32'(pulses), 32'd1);
        check("snap_busy_early_drop", 32'(early), 32'd0);

        // Reset mid-MAC: abort, clear outputs and coefficients.
        taps_v = 64'h0807060504030201;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_y", 32'(y), 32'd0);
        check("abort_valid", 32'(y_valid), 32'd0);
        tick();
        reset  = 1'b0;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (y_valid || busy) pulses++;
        end
        check("abort_no_activity", 32'(pulses), 32'd0);
        run_vec(64'h0807060504030201, lat, yv, bcnt);
        check("abort_rerun_lat", 32'(lat), 32'd9);
        check("abort_rerun_y", 32'(yv), 32'd0);

        // Back-to-back with start held; coef write blocked in MAC and accepted in IDLE.
        load_coefs(64'h0101010101010101);
        taps_v = 64'h0807060504030201;
        start  = 1'b1;
        pulses = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (n == 9 || n == 19 || n == 29) begin
                check($sformatf("b2b_valid_T%0d", n), 32'(y_valid), 32'd1);
                check($sformatf("b2b_y_T%0d", n), 32'(y), (n == 9) ? 32'd36 : 32'd40);
            end else if (y_valid) begin
                pulses++;
            end
            if (n == 3 || n == 9) begin
                coef_we   = 1'b1;
                coef_addr = 3'd0;
                coef_data = 8'd5;
            end else begin
                coef_we   = 1'b0;
            end
        end
        start = 1'b0;
        check("b2b_extra_pulses", 32'(pulses), 32'd0);
        tick();
        check("b2b_end_valid_low", 32'(y_valid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fir_tap_mac.md
# fir_tap_mac

Sequential multiply-accumulate engine that reads the 8-tap sample window (A7..A0) produced by the FIFO tap-delay system. It computes one FIR output sample per start request using a single shared multiplier over 8 cycles. Coefficients come from an internal 8-entry register bank that the control logic writes. The block sits between the tap-delay stage and the filter output register.

## Interface
- DATA_W, 8, tap width; taps are unsigned.
- COEF_W, 8, coefficient width; coefficients are two's-complement signed.
- OUT_W, 16, output width; output is signed.
- SHIFT, 0, arithmetic right shift applied to the accumulator before output.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  requests one filter computation; sampled on the rising edge.
- A7..A0  input  DATA_W each  tap window; Ak pairs with coefficient k.
- coef_we  input  1  coefficient write strobe.
- coef_addr  input  3  coefficient index 0..7.
- coef_data  input  COEF_W  coefficient write value.
- busy  output  1  high while a computation is in progress.
- y  output  OUT_W  filtered sample; held until the next result.
- y_valid  output  1  one-cycle pulse when y updates.

## Operation
- Reset values: busy=0, y=0, y_valid=0, all coefficients=0, accumulator=0, index=0, state=IDLE.
- States:
  - IDLE: start=1 snapshots A7..A0 into internal registers, clears acc and idx, then moves to MAC; busy=1.
  - MAC: acc += zext(tap[idx]) * coef[idx], then idx++. When idx=7 the block moves to OUT.
  - OUT: y <= sat_or_wrap(acc >>> SHIFT), y_valid <= 1, busy <= 0, then back to IDLE.
- Arithmetic:
  - Product is 17-bit signed: a 9-bit zero-extended tap times an 8-bit signed coefficient.
  - Accumulator is 20-bit signed, so no internal overflow is possible.
  - The shift is arithmetic (rounds toward minus infinity).
- The snapshot isolates the computation: tap changes after start is accepted do not affect the result.
- start while busy=1 is ignored; no request is queued.
- coef_we while busy=1 is dropped, so the coefficient bank is stable during MAC.
- coef_we in IDLE writes coef[coef_addr] at the edge. If start=1 at the same edge, the MAC uses the new value.
- Reset asserted mid-operation:
  - Aborts immediately: no y_valid, y=0, busy=0.
  - Coefficients are cleared; they must be reloaded.

## Timing
- start sampled at edge T0 → busy high after T0.
- MAC accumulates at edges T1..T8.
- y and y_valid update at edge T9; busy falls at T9. Latency is 9 cycles from start to y_valid.
- y_valid is high for exactly one cycle. The state is IDLE in that same cycle, so start=1 then is accepted.
- start held continuously gives one result every 10 cycles.
- Coefficient write-to-use latency: 0 cycles.

## Configuration
- FIR_MAC_SAT_EN:
  - Defined: the shifted accumulator is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Undefined: y takes the low OUT_W bits of the shifted accumulator (two's-complement wrap).

## Test plan
- Reset: assert reset with clk running → y=0, y_valid=0, busy=0; any start before release gives no activity.
- Basic FIR: coef[0..7]=1, A0..A7=1..8, pulse start → y_valid at the 9th edge after start, y=36, busy high for 9 cycles.
- Overflow: coef[all]=127, taps all 255, SHIFT=0 → acc=259080; with FIR_MAC_SAT_EN y=32767 (0x7FFF), without y=0xF408.
- Snapshot and ignored start: start, then change all taps to 0 and pulse start again during MAC → single y_valid, y equals the original-tap result, busy never drops early.
- Reset mid-MAC: assert reset at T4 → no y_valid, busy=0, y=0. After release, start with the same taps (coefficients now 0) gives y=0.
- Back-to-back and write-blocking: hold start high for 30 cycles → y_valid at T9, T19, T29. coef_we with coef_addr=0, coef_data=5 at T3 is ignored; the same write at T9 (IDLE) is used by the computation accepted at T10.
